sc_game_scheduler: RTL

- Game-sequencing controller for the LED-matrix driving game.
- Runs the IDLE/PLAY/CRASH/OVER flow and times the background scroll with a programmable tick period that shortens as the score rises.
- Issues active-low one-cycle strobes to the background shift register (scroll), the score up-counter (upcount) and a clear line.
- Consumes the debounced start button and the active-low collision flag from the car/obstacle comparator.

---
 rtl/sc_game_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sc_game_scheduler.sv
// sc_game_scheduler
// Sequencing controller for the LED-matrix driving game. Runs the
// IDLE -> PLAY -> CRASH -> OVER flow and times the background scroll with a
// tick period that shortens each time the score crosses a level boundary.
//
// Ports
//   SC_GAMESCHEDULER_CLOCK_50          system clock
//   SC_GAMESCHEDULER_RESET_InHigh      asynchronous active-high reset
//   SC_GAMESCHEDULER_startButton_InLow debounced start level, low = pressed
//   SC_GAMESCHEDULER_collision_InLow   low = car overlaps obstacle
//   SC_GAMESCHEDULER_scroll_OutLow     one-cycle low strobe, shift background
//   SC_GAMESCHEDULER_upcount_OutLow    one-cycle low strobe to score counter
//   SC_GAMESCHEDULER_clear_OutLow      low = hold background and score cleared
//   SC_GAMESCHEDULER_state_Out         IDLE=00 PLAY=01 CRASH=10 OVER=11
//   SC_GAMESCHEDULER_level_Out         current level, saturates at 15
//   SC_GAMESCHEDULER_lives_Out         remaining lives
module sc_game_scheduler #(
    parameter int unsigned PERIOD_WIDTH   = 26,
    parameter int unsigned PERIOD_INIT    = 25000000,
    parameter int unsigned PERIOD_MIN     = 5000000,
    parameter int unsigned PERIOD_STEP    = 2500000,
    parameter int unsigned LEVEL_UP_SCORE = 10,
    parameter int unsigned SCORE_WIDTH    = 8,
    parameter int unsigned CRASH_TICKS    = 3,
    parameter int unsigned LIVES          = 3
) (
    input  logic       SC_GAMESCHEDULER_CLOCK_50,
    input  logic       SC_GAMESCHEDULER_RESET_InHigh,
    input  logic       SC_GAMESCHEDULER_startButton_InLow,
    input  logic       SC_GAMESCHEDULER_collision_InLow,
    output logic       SC_GAMESCHEDULER_scroll_OutLow,
    output logic       SC_GAMESCHEDULER_upcount_OutLow,
    output logic       SC_GAMESCHEDULER_clear_OutLow,
    output logic [1:0] SC_GAMESCHEDULER_state_Out,
    output logic [3:0] SC_GAMESCHEDULER_level_Out,
    output logic [2:0] SC_GAMESCHEDULER_lives_Out
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_CRASH = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam int unsigned CRASH_W = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
    localparam int unsigned LU_W    = (LEVEL_UP_SCORE > 1) ? $clog2(LEVEL_UP_SCORE) : 1;

    localparam logic [PERIOD_WIDTH-1:0] P_INIT     = PERIOD_WIDTH'(PERIOD_INIT);
    localparam logic [PERIOD_WIDTH-1:0] P_MIN      = PERIOD_WIDTH'(PERIOD_MIN);
    localparam logic [PERIOD_WIDTH-1:0] P_STEP     = PERIOD_WIDTH'(PERIOD_STEP);
    localparam logic [CRASH_W-1:0]      CRASH_LAST = CRASH_W'(CRASH_TICKS - 1);
    localparam logic [LU_W-1:0]         LU_LAST    = LU_W'(LEVEL_UP_SCORE - 1);
    localparam logic [SCORE_WIDTH-1:0]  SCORE_MAX  = '1;
    localparam logic [2:0]              LIVES_INIT = 3'(LIVES);

    logic [1:0]              r_state,     w_state_d;
    logic [PERIOD_WIDTH-1:0] r_tick_cnt,  w_tick_cnt_d;
    logic [PERIOD_WIDTH-1:0] r_period,    w_period_d;
    logic [SCORE_WIDTH-1:0]  r_score,     w_score_d;
    logic [LU_W-1:0]         r_lu_cnt,    w_lu_cnt_d;   // score increments since last level-up
    logic [CRASH_W-1:0]      r_crash_cnt, w_crash_cnt_d;
    logic [3:0]              r_level,     w_level_d;
    logic [2:0]              r_lives,     w_lives_d;
    logic                    r_start_prev;
    logic                    r_scroll,    w_scroll_d;
    logic                    r_upcount,   w_upcount_d;
    logic                    r_clear,     w_clear_d;
    logic                    w_press;
    logic                    w_tick;
    logic                    w_timed;

    assign w_press = r_start_prev & ~SC_GAMESCHEDULER_startButton_InLow;
    assign w_timed = (r_state == ST_PLAY) || (r_state == ST_CRASH);
    assign w_tick  = w_timed && (r_tick_cnt == r_period - PERIOD_WIDTH'(1));

    always_comb begin
        w_state_d     = r_state;
        w_period_d    = r_period;
        w_score_d     = r_score;
        w_lu_cnt_d    = r_lu_cnt;
        w_crash_cnt_d = r_crash_cnt;
        w_level_d     = r_level;
        w_lives_d     = r_lives;
        w_scroll_d    = 1'b1;
        w_upcount_d   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_d  = ST_PLAY;
                    w_level_d  = 4'd0;
                    w_lives_d  = LIVES_INIT;
                    w_period_d = P_INIT;
                    w_score_d  = '0;
                    w_lu_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                // Collision wins over a tick landing on the same cycle.
                if (!SC_GAMESCHEDULER_collision_InLow) begin
                    w_state_d = ST_CRASH;
                end else if (w_tick) begin
                    w_scroll_d = 1'b0;
                    if (r_score != SCORE_MAX) begin
                        w_score_d   = r_score + SCORE_WIDTH'(1);
                        w_upcount_d = 1'b0;
                        if (r_lu_cnt == LU_LAST) begin
                            w_lu_cnt_d = '0;
                            if (r_level != 4'hF) begin
                                w_level_d = r_level + 4'd1;
                            end
                            // Subtract without underflow: floor at P_MIN.
                            if (r_period - P_MIN >= P_STEP) begin
                                w_period_d = r_period - P_STEP;
                            end else begin
                                w_period_d = P_MIN;
                            end
                        end else begin
                            w_lu_cnt_d = r_lu_cnt + LU_W'(1);
                        end
                    end
                end
            end
            ST_CRASH: begin
                if (w_tick) begin
                    if (r_crash_cnt == CRASH_LAST) begin
                        w_lives_d = r_lives - 3'd1;
                        w_state_d = (r_lives == 3'd1) ? ST_OVER : ST_PLAY;
                    end else begin
                        w_crash_cnt_d = r_crash_cnt + CRASH_W'(1);
                    end
                end
            end
            default: begin
                if (w_press) begin
                    w_state_d = ST_IDLE;
                end
            end
        endcase

        // Tick and crash counters restart on every state entry.
        if (w_state_d != r_state) begin
            w_tick_cnt_d  = '0;
            w_crash_cnt_d = '0;
        end else if (w_timed) begin
            w_tick_cnt_d = w_tick ? '0 : r_tick_cnt + PERIOD_WIDTH'(1);
        end else begin
            w_tick_cnt_d = '0;
        end

        w_clear_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge SC_GAMESCHEDULER_CLOCK_50 or posedge SC_GAMESCHEDULER_RESET_InHigh) begin
        if (SC_GAMESCHEDULER_RESET_InHigh) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_period     <= P_INIT;
            r_score      <= '0;
            r_lu_cnt     <= '0;
            r_crash_cnt  <= '0;
            r_level      <= 4'd0;
            r_lives      <= LIVES_INIT;
            r_start_prev <= 1'b1;
            r_scroll     <= 1'b1;
            r_upcount    <= 1'b1;
            r_clear      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_tick_cnt   <= w_tick_cnt_d;
            r_period     <= w_period_d;
            r_score      <= w_score_d;
            r_lu_cnt     <= w_lu_cnt_d;
            r_crash_cnt  <= w_crash_cnt_d;
            r_level      <= w_level_d;
            r_lives      <= w_lives_d;
            r_start_prev <= SC_GAMESCHEDULER_startButton_InLow;
            r_scroll     <= w_scroll_d;
            r_upcount    <= w_upcount_d;
            r_clear      <= w_clear_d;
        end
    end

    assign SC_GAMESCHEDULER_scroll_OutLow  = r_scroll;
    assign SC_GAMESCHEDULER_upcount_OutLow = r_upcount;
    assign SC_GAMESCHEDULER_clear_OutLow   = r_clear;
    assign SC_GAMESCHEDULER_state_Out      = r_state;
    assign SC_GAMESCHEDULER_level_Out      = r_level;
    assign SC_GAMESCHEDULER_lives_Out      = r_lives;

endmodule
